// File: rtl/seg_pkg.sv
// Segment codes, bit order and nibble decode shared by the scan driver.
// Segment bits are {dp,g,f,e,d,c,b,a}, active high.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // F is the field separator; A..E are unused codes shown blank.
    function automatic logic [7:0] nib2seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hF:    return SEG_DASH;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to seven-segment code, one instance per bank.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    assign seg = nib2seg(nib);

endmodule

// File: rtl/seg_scan.sv
// Eight-digit, two-bank seven-segment scan driver with per-digit blink.
// Data and blink mask are snapshotted once per frame so a frame never tears.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_data2,
    output logic [7:0]  seg_cs
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;
    logic [1:0]    idx;
    logic [31:0]   sh_data;
    logic [7:0]    sh_mask;

    logic          tick;
    logic          blink_tog;
    logic [1:0]    nidx;
    logic          frame_start;
    logic [31:0]   eff_data;
    logic [7:0]    eff_mask;
    logic [3:0]    nib_r, nib_l;
    logic [7:0]    seg_r, seg_l;
    logic          blank_r, blank_l;

    assign tick        = (div_cnt == DW'(SCAN_DIV - 1));
    assign blink_tog   = (blink_cnt == BW'(BLINK_DIV - 1));
    assign nidx        = idx + 2'd1;
    assign frame_start = (nidx == 2'd0);

    // The step that opens a frame shows the live inputs it is latching.
    assign eff_data = frame_start ? data       : sh_data;
    assign eff_mask = frame_start ? blink_mask : sh_mask;

    assign nib_r   = eff_data[{nidx, 2'b00} +: 4];
    assign nib_l   = eff_data[{1'b1, nidx, 2'b00} +: 4];
    assign blank_r = !phase && eff_mask[{1'b0, nidx}];
    assign blank_l = !phase && eff_mask[{1'b1, nidx}];

    seg_decode u_dec_r (.nib(nib_r), .seg(seg_r));
    seg_decode u_dec_l (.nib(nib_l), .seg(seg_l));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            idx       <= 2'd3;
            sh_data   <= '0;
            sh_mask   <= '0;
            seg_data  <= '0;
            seg_data2 <= '0;
            seg_cs    <= '0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            blink_cnt <= blink_tog ? '0 : blink_cnt + 1'b1;
            if (blink_tog)
                phase <= ~phase;
            // A coincident toggle is seen one step later: the tick reads the old phase.
            if (tick) begin
                idx <= nidx;
                if (frame_start) begin
                    sh_data <= data;
                    sh_mask <= blink_mask;
                end
                seg_data2 <= blank_r ? SEG_BLANK : seg_r;
                seg_data  <= blank_l ? SEG_BLANK : seg_l;
                seg_cs    <= 8'h11 << nidx;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed steps plus random data against a
// time-based reference model of the scan schedule.
module tb_seg_scan;

    localparam int SD = 4;
    localparam int BD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'h12F34F56;
    logic [7:0]  blink_mask = 8'h00;
    logic [7:0]  seg_data, seg_data2, seg_cs;

    seg_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .data(data), .blink_mask(blink_mask),
        .seg_data(seg_data), .seg_data2(seg_data2), .seg_cs(seg_cs)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          n = 0;        // edges since reset released
    int          m_idx = 3;
    bit          ticked = 0;
    logic [31:0] sd = '0;
    logic [7:0]  sm = '0;
    logic [7:0]  e_cs = '0, e_l = '0, e_r = '0;

    function automatic logic [7:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;
            4'h3: return 8'h4F;  4'h4: return 8'h66;  4'h5: return 8'h6D;
            4'h6: return 8'h7D;  4'h7: return 8'h07;  4'h8: return 8'h7F;
            4'h9: return 8'h6F;  4'hF: return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // One clock edge: advance the model, then compare all outputs.
    task automatic cyc();
        bit ph;
        @(posedge clk);
        ticked = 0;
        if (rst) begin
            n = 0; m_idx = 3; sd = '0; sm = '0;
            e_cs = '0; e_l = '0; e_r = '0;
        end else begin
            n++;
            if (n % SD == 0) begin
                ticked = 1;
                m_idx = (n / SD - 1) % 4;
                if (m_idx == 0) begin
                    sd = data;
                    sm = blink_mask;
                end
                // phase starts at 1 and flips at edges BD, 2*BD, ...; a tick sees the value before its edge
                ph = (((n - 1) / BD) % 2) == 0;
                e_r = dec(sd[4*m_idx +: 4]);
                e_l = dec(sd[4*(m_idx+4) +: 4]);
                if (!ph && sm[m_idx])   e_r = 8'h00;
                if (!ph && sm[m_idx+4]) e_l = 8'h00;
                e_cs = '0;
                e_cs[m_idx] = 1'b1;
                e_cs[m_idx+4] = 1'b1;
            end
        end
        #1;
        chk("seg_cs", seg_cs, e_cs);
        chk("seg_data", seg_data, e_l);
        chk("seg_data2", seg_data2, e_r);
    endtask

    task automatic step3(input string tag, input logic [7:0] cs, input logic [7:0] l, input logic [7:0] r);
        chk({tag, "_cs"}, seg_cs, cs);
        chk({tag, "_l"}, seg_data, l);
        chk({tag, "_r"}, seg_data2, r);
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("pre_tick_cs", seg_cs, 8'h00);
        end
        cyc();
        step3("first", 8'h11, 8'h4F, 8'h7D);
        repeat (SD) cyc();
        step3("idx1", 8'h22, 8'h40, 8'h6D);
        repeat (SD) cyc();
        step3("idx2", 8'h44, 8'h5B, 8'h40);

        // change data mid-frame: idx3 keeps the snapshot, next frame picks it up
        data = 32'h00000000;
        repeat (SD) cyc();
        step3("tear_idx3", 8'h88, 8'h06, 8'h66);
        repeat (SD) cyc();
        step3("tear_idx0", 8'h11, 8'h3F, 8'h3F);

        data = 32'h12F34F56;
        blink_mask = 8'h01;
        repeat (220) cyc();

        data = 32'hABCDEF98;
        blink_mask = 8'h00;
        repeat (20) cyc();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 0) data = $urandom;
            if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom);
            cyc();
        end

        // mid-frame reset at idx=2
        begin
            int budget = 20;
            while (!(ticked && m_idx == 2) && budget > 0) begin
                cyc();
                budget--;
            end
            nvec++;
            if (budget == 0) begin
                nerr++;
                $error("FAIL wait_idx2 observed=timeout expected=idx2 tick");
            end
        end
        rst = 1'b1;
        cyc();
        step3("midrst", 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        repeat (3) cyc();
        chk("midrst_hold_cs", seg_cs, 8'h00);
        cyc();
        chk("midrst_first_cs", seg_cs, 8'h11);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) data = $urandom;
            if ($urandom_range(0, 9) == 0) blink_mask = 8'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
